wb_port_arbiter: RTL and testbench

- Shares the two writeback ports (inst0/inst1 inputs of the writeback stage) among NUM_REQ execution units: ALU0, ALU1, MUL/DIV, LSU.
- Each cycle, grants up to two requesters in scoreboard-age order, with a starvation override. Results are registered into the port 0 / port 1 output slots.
- Sits between the execute units and the writeback stage. Honours the writeback stall and flush controls.

---
 rtl/wb_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the two writeback ports among NUM_REQ execution
// units (ALU0, ALU1, MUL/DIV, LSU). Each cycle the oldest valid result, by
// scoreboard age, goes to port 0 and the next oldest goes to port 1. A
// requester refused STARVE_LIMIT times is forced onto port 0. The granted
// results are registered into the port slots.
// Optional macro WB_ARB_PERF_CNT_EN adds the conflict/starvation counters.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

module wb_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SID_W        = `SCOREBOARD_SIZE_WIDTH + 1,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [5*NUM_REQ-1:0]     req_rd_i,
  input  logic [64*NUM_REQ-1:0]    req_value_i,
  input  logic [SID_W*NUM_REQ-1:0] req_sid_i,
  input  logic [NUM_REQ-1:0]       req_redirect_i,
  input  logic [64*NUM_REQ-1:0]    req_redirect_pc_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     port0_valid_o,
  output logic [4:0]               port0_rd_o,
  output logic [63:0]              port0_value_o,
  output logic [SID_W-1:0]         port0_sid_o,
  output logic                     port0_redirect_o,
  output logic [63:0]              port0_redirect_pc_o,
  output logic                     port1_valid_o,
  output logic [4:0]               port1_rd_o,
  output logic [63:0]              port1_value_o,
  output logic [SID_W-1:0]         port1_sid_o,
  output logic                     port1_redirect_o,
  output logic [63:0]              port1_redirect_pc_o
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_conflict_cnt_o,
  output logic [31:0]              perf_starve_cnt_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_LIMIT);

  // Handshake: a result transfers in the cycle where req_valid_i[k] and
  // req_ready_o[k] are both high; the requester holds every field stable while
  // valid and not ready. Ready depends combinationally on this cycle's inputs.

  logic [4:0]       rd_a    [NUM_REQ];
  logic [63:0]      value_a [NUM_REQ];
  logic [SID_W-1:0] sid_a   [NUM_REQ];
  logic [63:0]      pc_a    [NUM_REQ];
  logic [CNT_W-1:0] wait_cnt [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_a[g]    = req_rd_i[g*5 +: 5];
    assign value_a[g] = req_value_i[g*64 +: 64];
    assign sid_a[g]   = req_sid_i[g*SID_W +: SID_W];
    assign pc_a[g]    = req_redirect_pc_i[g*64 +: 64];
  end

  // a is older than b; the MSB is the wrap bit, so differing wraps invert the order
  function automatic logic older(input logic [SID_W-1:0] a, input logic [SID_W-1:0] b);
    if (a[SID_W-1] == b[SID_W-1]) return a[SID_W-2:0] < b[SID_W-2:0];
    else return a[SID_W-2:0] > b[SID_W-2:0];
  endfunction

  logic             go;
  logic             old_found, starve_found, p0_found, p1_found;
  logic [IDX_W-1:0] old_idx, starve_idx, p0_idx, p1_idx;
  logic [NUM_REQ-1:0] grant;

  // Port selection: starvation override or oldest for port 0, next oldest for port 1
  always_comb begin
    go           = !stall_i && !flush_i;
    old_found    = 1'b0;
    old_idx      = '0;
    starve_found = 1'b0;
    starve_idx   = '0;
    p1_found     = 1'b0;
    p1_idx       = '0;
    grant        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k] && (!old_found || older(sid_a[k], sid_a[old_idx]))) begin
        old_found = 1'b1;
        old_idx   = IDX_W'(k);
      end
      if (!starve_found && req_valid_i[k] && wait_cnt[k] == STARVE_CNT) begin
        starve_found = 1'b1;
        starve_idx   = IDX_W'(k);
      end
    end
    p0_found = starve_found || old_found;
    p0_idx   = starve_found ? starve_idx : old_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k] && IDX_W'(k) != p0_idx &&
          (!p1_found || older(sid_a[k], sid_a[p1_idx]))) begin
        p1_found = 1'b1;
        p1_idx   = IDX_W'(k);
      end
    end
    // a redirecting port 0 result kills every younger result, so port 1 stays empty
    if (!p0_found || req_redirect_i[p0_idx]) p1_found = 1'b0;
    if (go && p0_found) grant[p0_idx] = 1'b1;
    if (go && p1_found) grant[p1_idx] = 1'b1;
  end

  assign req_ready_o = rst_n ? grant : '0;

  // Output slots: flush drops valid/redirect, stall holds, else load the grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port0_valid_o <= 1'b0; port0_rd_o <= '0; port0_value_o <= '0;
      port0_sid_o <= '0; port0_redirect_o <= 1'b0; port0_redirect_pc_o <= '0;
      port1_valid_o <= 1'b0; port1_rd_o <= '0; port1_value_o <= '0;
      port1_sid_o <= '0; port1_redirect_o <= 1'b0; port1_redirect_pc_o <= '0;
    end else if (flush_i) begin
      port0_valid_o <= 1'b0; port0_redirect_o <= 1'b0;
      port1_valid_o <= 1'b0; port1_redirect_o <= 1'b0;
    end else if (!stall_i) begin
      port0_valid_o <= p0_found;
      port0_redirect_o <= p0_found && req_redirect_i[p0_idx];
      if (p0_found) begin
        port0_rd_o <= rd_a[p0_idx]; port0_value_o <= value_a[p0_idx];
        port0_sid_o <= sid_a[p0_idx]; port0_redirect_pc_o <= pc_a[p0_idx];
      end
      port1_valid_o <= p1_found;
      port1_redirect_o <= p1_found && req_redirect_i[p1_idx];
      if (p1_found) begin
        port1_rd_o <= rd_a[p1_idx]; port1_value_o <= value_a[p1_idx];
        port1_sid_o <= sid_a[p1_idx]; port1_redirect_pc_o <= pc_a[p1_idx];
      end
    end
  end

  // Wait counters: count refused cycles of a valid requester, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) wait_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (flush_i || !req_valid_i[k]) wait_cnt[k] <= '0;
        else if (stall_i) wait_cnt[k] <= wait_cnt[k];
        else if (grant[k]) wait_cnt[k] <= '0;
        else if (wait_cnt[k] != STARVE_CNT) wait_cnt[k] <= wait_cnt[k] + 1'b1;
      end
    end
  end

`ifdef WB_ARB_PERF_CNT_EN
  // Performance counters: free-running, wrap, unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt_o <= '0;
      perf_starve_cnt_o   <= '0;
    end else begin
      if (go && $countones(req_valid_i) >= 3) perf_conflict_cnt_o <= perf_conflict_cnt_o + 1'b1;
      if (go && starve_found) perf_starve_cnt_o <= perf_starve_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter.
// Inputs change just after the falling edge; ready is sampled 1 time unit
// later, and the registered slots 1 time unit after the rising edge.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

module tb_wb_port_arbiter;
  localparam int NR = 4;
  localparam int SID_W = `SCOREBOARD_SIZE_WIDTH + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] req_valid, req_redirect, req_ready;
  logic [5*NR-1:0] req_rd;
  logic [64*NR-1:0] req_value, req_pc;
  logic [SID_W*NR-1:0] req_sid;
  logic stall, flush;
  logic p0_valid, p0_redirect, p1_valid, p1_redirect;
  logic [4:0] p0_rd, p1_rd;
  logic [63:0] p0_value, p1_value, p0_pc, p1_pc;
  logic [SID_W-1:0] p0_sid, p1_sid;
`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] perf_conflict, perf_starve;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [SID_W-1:0] exp_q[$];

  wb_port_arbiter #(.NUM_REQ(NR), .SID_W(SID_W), .STARVE_LIMIT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_rd_i(req_rd), .req_value_i(req_value),
    .req_sid_i(req_sid), .req_redirect_i(req_redirect),
    .req_redirect_pc_i(req_pc), .req_ready_o(req_ready),
    .stall_i(stall), .flush_i(flush),
    .port0_valid_o(p0_valid), .port0_rd_o(p0_rd), .port0_value_o(p0_value),
    .port0_sid_o(p0_sid), .port0_redirect_o(p0_redirect), .port0_redirect_pc_o(p0_pc),
    .port1_valid_o(p1_valid), .port1_rd_o(p1_rd), .port1_value_o(p1_value),
    .port1_sid_o(p1_sid), .port1_redirect_o(p1_redirect), .port1_redirect_pc_o(p1_pc)
`ifdef WB_ARB_PERF_CNT_EN
    , .perf_conflict_cnt_o(perf_conflict), .perf_starve_cnt_o(perf_starve)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by itself");
    $fatal(1, "timeout");
  end

  task automatic clear_reqs();
    req_valid = '0; req_rd = '0; req_value = '0; req_sid = '0;
    req_redirect = '0; req_pc = '0;
  endtask

  task automatic set_req(input int k, input logic [SID_W-1:0] sid, input logic [4:0] rd,
                         input logic [63:0] val, input logic redir, input logic [63:0] pc);
    req_valid[k] = 1'b1;
    req_sid[k*SID_W +: SID_W] = sid;
    req_rd[k*5 +: 5] = rd;
    req_value[k*64 +: 64] = val;
    req_redirect[k] = redir;
    req_pc[k*64 +: 64] = pc;
  endtask

  // leaves the bench just after a falling edge with reset released
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_reqs();
    set_req(0, 5'd3, 5'd5, 64'hAA, 1'b0, 64'h0);
    @(negedge clk); #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++;
    if ({p0_valid, p1_valid, p0_redirect, p1_redirect} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_valids: got %b want 0000", {p0_valid, p1_valid, p0_redirect, p1_redirect});
    end
    n_checks++;
    if (p0_value !== 64'h0 || p0_sid !== '0 || p1_rd !== 5'd0) begin
      n_errors++; $display("FAIL reset_data: p0_value=%h p0_sid=%h p1_rd=%h want 0", p0_value, p0_sid, p1_rd);
    end
    // grant once, then pull reset asynchronously in mid-cycle
    do_reset();
    set_req(0, 5'd3, 5'd5, 64'hAA, 1'b0, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++;
    if (p0_valid !== 1'b0 || p0_rd !== 5'd0 || p0_value !== 64'h0) begin
      n_errors++; $display("FAIL async_reset: valid=%b rd=%0d value=%h want 0/0/0", p0_valid, p0_rd, p0_value);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 5'd3, 5'd5, 64'hAA, 1'b0, 64'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (p0_valid !== 1'b1 || p0_rd !== 5'd5 || p0_value !== 64'hAA || p1_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_out: p0v=%b rd=%0d val=%h p1v=%b want 1/5/aa/0", p0_valid, p0_rd, p0_value, p1_valid);
    end
    @(negedge clk);
    clear_reqs();
    @(posedge clk); #1;
    n_checks++;
    if (p0_valid !== 1'b0 || p1_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_idle: p0v=%b p1v=%b want 0/0", p0_valid, p1_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_age_order();
    logic [SID_W-1:0] e;
    do_reset();
    set_req(0, 5'd3, 5'd1, 64'h10, 1'b0, 64'h0);
    set_req(1, 5'd2, 5'd2, 64'h20, 1'b0, 64'h0);
    set_req(2, 5'd4, 5'd3, 64'h30, 1'b0, 64'h0);
    set_req(3, 5'd6, 5'd4, 64'h40, 1'b0, 64'h0);
    exp_q.push_back(5'd2); exp_q.push_back(5'd3);
    exp_q.push_back(5'd4); exp_q.push_back(5'd6);
    #1;
    n_checks++;
    if (req_ready !== 4'b0011) begin n_errors++; $display("FAIL age_ready1: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (p0_sid !== e || p0_valid !== 1'b1) begin n_errors++; $display("FAIL age_p0_1: sid=%0d v=%b want %0d/1", p0_sid, p0_valid, e); end
    e = exp_q.pop_front();
    n_checks++;
    if (p1_sid !== e || p1_valid !== 1'b1) begin n_errors++; $display("FAIL age_p1_1: sid=%0d v=%b want %0d/1", p1_sid, p1_valid, e); end
    @(negedge clk);
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b1100) begin n_errors++; $display("FAIL age_ready2: got %b want 1100", req_ready); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (p0_sid !== e) begin n_errors++; $display("FAIL age_p0_2: sid=%0d want %0d", p0_sid, e); end
    e = exp_q.pop_front();
    n_checks++;
    if (p1_sid !== e) begin n_errors++; $display("FAIL age_p1_2: sid=%0d want %0d", p1_sid, e); end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(0, 5'b1_0001, 5'd1, 64'h1, 1'b0, 64'h0);
    set_req(1, 5'b0_1110, 5'd2, 64'h2, 1'b0, 64'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0011) begin n_errors++; $display("FAIL wrap_ready: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (p0_sid !== 5'b0_1110 || p1_sid !== 5'b1_0001) begin
      n_errors++; $display("FAIL wrap_order: p0_sid=%b p1_sid=%b want 01110/10001", p0_sid, p1_sid);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_redirect();
    do_reset();
    set_req(0, 5'd1, 5'd9, 64'h55, 1'b1, 64'h8000_0100);
    set_req(1, 5'd2, 5'd10, 64'h66, 1'b0, 64'h0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL redir_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (p0_redirect !== 1'b1 || p0_pc !== 64'h8000_0100 || p1_valid !== 1'b0) begin
      n_errors++; $display("FAIL redir_out: redir=%b pc=%h p1v=%b want 1/80000100/0", p0_redirect, p0_pc, p1_valid);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL redir_next: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (p0_redirect !== 1'b0 || p0_sid !== 5'd2) begin
      n_errors++; $display("FAIL redir_clear: redir=%b sid=%0d want 0/2", p0_redirect, p0_sid);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  // req3 youngest; req0/req1 re-present a result every cycle
  task automatic test_starvation();
    logic [3:0] exp_rdy;
    do_reset();
    set_req(0, 5'd1, 5'd1, 64'h1, 1'b0, 64'h0);
    set_req(1, 5'd2, 5'd2, 64'h2, 1'b0, 64'h0);
    set_req(3, 5'd15, 5'd3, 64'h3, 1'b0, 64'h0);
    for (int i = 1; i <= 8; i++) begin
      exp_rdy = (i == 8) ? 4'b1001 : 4'b0011;
      #1;
      n_checks++;
      if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL starve_cycle%0d: ready=%b want %b", i, req_ready, exp_rdy); end
      @(posedge clk); #1;
      @(negedge clk);
    end
    // registered slots now hold the cycle-8 grant
    n_checks++;
    if (p0_sid !== 5'd15 || p1_sid !== 5'd1) begin
      n_errors++; $display("FAIL starve_out: p0_sid=%0d p1_sid=%0d want 15/1", p0_sid, p1_sid);
    end
    // new req3 result must start its wait count from zero
    #1;
    n_checks++;
    if (req_ready !== 4'b0011) begin n_errors++; $display("FAIL starve_reset_cnt: ready=%b want 0011", req_ready); end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_stall_flush();
    logic [3:0] exp_rdy;
    do_reset();
    set_req(0, 5'd1, 5'd7, 64'h11, 1'b0, 64'h0);
    set_req(1, 5'd2, 5'd8, 64'h22, 1'b0, 64'h0);
    set_req(3, 5'd15, 5'd3, 64'h33, 1'b0, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL stall_ready%0d: got %b want 0000", i, req_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (p0_valid !== 1'b1 || p0_rd !== 5'd7 || p0_value !== 64'h11 || p1_valid !== 1'b1 || p1_rd !== 5'd8) begin
        n_errors++; $display("FAIL stall_hold%0d: p0v=%b rd0=%0d val0=%h p1v=%b rd1=%0d want 1/7/11/1/8",
                             i, p0_valid, p0_rd, p0_value, p1_valid, p1_rd);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (p0_valid !== 1'b0 || p1_valid !== 1'b0 || p0_rd !== 5'd7) begin
      n_errors++; $display("FAIL flush_out: p0v=%b p1v=%b rd0=%0d want 0/0/7", p0_valid, p1_valid, p0_rd);
    end
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    // req3's count was cleared by the flush: a full 7 refusals before its grant
    for (int i = 1; i <= 8; i++) begin
      exp_rdy = (i == 8) ? 4'b1001 : 4'b0011;
      #1;
      n_checks++;
      if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL flush_cnt_cycle%0d: ready=%b want %b", i, req_ready, exp_rdy); end
      @(posedge clk); #1;
      @(negedge clk);
    end
    clear_reqs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_age_order();
    test_wrap();
    test_redirect();
    test_starvation();
    test_stall_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
